// File: rtl/noc_pkg.sv
// Shared definitions for the NoC packet sink: flit layout widths/offsets,
// accept-FSM encoding and the modular timestamp subtraction.
package noc_pkg;

  localparam int NOC_DATA_W = 32;
  localparam int NOC_ID_W   = 6;
  localparam int NOC_PID_W  = 8;

  // Flit layout from MSB down: {pkt_id, src_id, dst_id, inj_ts}
  function automatic int ts_lsb();
    return 0;
  endfunction

  function automatic int dst_lsb(input int ts_w);
    return ts_w;
  endfunction

  function automatic int src_lsb(input int ts_w, input int id_w);
    return ts_w + id_w;
  endfunction

  function automatic int pid_lsb(input int ts_w, input int id_w);
    return ts_w + 2 * id_w;
  endfunction

  typedef enum logic {
    WAIT_REQ = 1'b0,
    GRANT    = 1'b1
  } accept_state_t;

  // Callers truncate the result to the timestamp width, giving mod 2^TS_W.
  function automatic logic [31:0] ts_diff(input logic [31:0] now_ts, input logic [31:0] inj_ts);
    return now_ts - inj_ts;
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Generic single-clock FIFO with registered read data; FIFO_DEPTH must be a
// power of two so the pointers wrap naturally.
module noc_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        pop,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_reg;
  logic [AW-1:0]         rd_ptr_reg;
  logic [AW:0]           level_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (level_reg == (AW+1)'(FIFO_DEPTH));
  assign empty   = (level_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = level_reg;
  assign rdata   = rdata_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
      rdata_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
        rdata_reg  <= mem[rd_ptr_reg];
      end
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/noc_packet_sink.sv
// Router Local-port sink: req/gnt accept FSM, buffered drain, latency and
// misroute statistics. Define NOC_SINK_LOG_EN for a per-sink simulation log.
module noc_packet_sink
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = NOC_DATA_W,
  parameter int ID_W       = NOC_ID_W,
  parameter int PID_W      = NOC_PID_W,
  parameter int TS_W       = DATA_WIDTH - 2 * ID_W - PID_W,
  parameter int MODULE_ID  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       packet_in,
  input  logic                        req_up_str,
  output logic                        gnt_up_str,
  output logic                        up_str_full,
  input  logic                        drain_en,
  input  logic                        stats_clr,
  output logic                        rx_valid,
  output logic [ID_W-1:0]             rx_src,
  output logic [PID_W-1:0]            rx_pkt_id,
  output logic [TS_W-1:0]             rx_latency,
  output logic [CNT_W-1:0]            pkt_count,
  output logic [CNT_W-1:0]            lat_sum,
  output logic [TS_W-1:0]             lat_max,
  output logic [CNT_W-1:0]            misroute_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int DST_LSB = dst_lsb(TS_W);
  localparam int SRC_LSB = src_lsb(TS_W, ID_W);
  localparam int PID_LSB = pid_lsb(TS_W, ID_W);

  logic [CNT_W-1:0]      cycle_cnt_reg;
  accept_state_t         state_reg, state_next;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [TS_W-1:0]       lat_in;
  logic [DATA_WIDTH-1:0] entry_in, entry_out;
  logic                  rx_valid_reg, up_str_full_reg;
  logic [ID_W-1:0]       rx_dst;
  logic                  misroute;
  logic [CNT_W:0]        sum_wide;
  logic [CNT_W-1:0]      lat_sum_next;
  logic [CNT_W-1:0]      pkt_count_reg, lat_sum_reg, misroute_count_reg;
  logic [TS_W-1:0]       lat_max_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle_cnt_reg <= '0;
    else        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
  end

  // Latency is fixed at acceptance, so the queue stores it in place of inj_ts.
  assign lat_in   = TS_W'(ts_diff(32'(cycle_cnt_reg[TS_W-1:0]), 32'(packet_in[TS_W-1:0])));
  assign entry_in = {packet_in[DATA_WIDTH-1:TS_W], lat_in};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= WAIT_REQ;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    case (state_reg)
      WAIT_REQ: begin
        if (req_up_str && !fifo_full) begin
          push       = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT:   state_next = WAIT_REQ;
      default: state_next = WAIT_REQ;
    endcase
  end

  // GRANT lasts exactly one cycle, so the state register is the grant pulse.
  assign gnt_up_str = (state_reg == GRANT);
  assign pop        = drain_en && !fifo_empty;

  noc_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (entry_in),
    .pop   (pop),
    .rdata (entry_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid_reg    <= 1'b0;
      up_str_full_reg <= 1'b0;
    end else begin
      rx_valid_reg    <= pop;
      up_str_full_reg <= fifo_full;
    end
  end

  assign rx_valid    = rx_valid_reg;
  assign up_str_full = up_str_full_reg;
  assign rx_pkt_id   = entry_out[PID_LSB +: PID_W];
  assign rx_src      = entry_out[SRC_LSB +: ID_W];
  assign rx_dst      = entry_out[DST_LSB +: ID_W];
  assign rx_latency  = entry_out[TS_W-1:0];
  assign misroute    = (rx_dst != ID_W'(MODULE_ID));

  assign sum_wide     = (CNT_W+1)'(lat_sum_reg) + (CNT_W+1)'(rx_latency);
  assign lat_sum_next = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];

  // Statistics fold in during the rx_valid cycle; a clear in that cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_count_reg      <= '0;
      lat_sum_reg        <= '0;
      lat_max_reg        <= '0;
      misroute_count_reg <= '0;
    end else if (stats_clr) begin
      pkt_count_reg      <= '0;
      lat_sum_reg        <= '0;
      lat_max_reg        <= '0;
      misroute_count_reg <= '0;
    end else if (rx_valid_reg) begin
      if (pkt_count_reg != {CNT_W{1'b1}}) pkt_count_reg <= pkt_count_reg + CNT_W'(1);
      lat_sum_reg <= lat_sum_next;
      if (rx_latency > lat_max_reg) lat_max_reg <= rx_latency;
      if (misroute && (misroute_count_reg != {CNT_W{1'b1}}))
        misroute_count_reg <= misroute_count_reg + CNT_W'(1);
    end
  end

  assign pkt_count      = pkt_count_reg;
  assign lat_sum        = lat_sum_reg;
  assign lat_max        = lat_max_reg;
  assign misroute_count = misroute_count_reg;

`ifdef NOC_SINK_LOG_EN
  always @(posedge clk) begin
    if (rx_valid_reg)
      $display("noc_sink_%0d: %0t %0d %0d %0d %0d %0d %0b", MODULE_ID, $time, cycle_cnt_reg,
               rx_src, MODULE_ID, rx_pkt_id, rx_latency, misroute);
  end
`else
`endif

endmodule

// File: tb/tb_noc_packet_sink.sv
// Directed self-checking bench for noc_packet_sink (MODULE_ID=9, depth 4).
module tb_noc_packet_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] packet_in = '0;
  logic        req_up_str = 1'b0;
  logic        gnt_up_str;
  logic        up_str_full;
  logic        drain_en = 1'b0;
  logic        stats_clr = 1'b0;
  logic        rx_valid;
  logic [5:0]  rx_src;
  logic [7:0]  rx_pkt_id;
  logic [11:0] rx_latency;
  logic [31:0] pkt_count;
  logic [31:0] lat_sum;
  logic [11:0] lat_max;
  logic [31:0] misroute_count;
  logic [2:0]  fifo_level;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  logic [7:0]  rx_pid_q[$];
  logic [31:0] tb_cyc;

  noc_packet_sink #(
    .DATA_WIDTH (32),
    .ID_W       (6),
    .PID_W      (8),
    .TS_W       (12),
    .MODULE_ID  (9),
    .FIFO_DEPTH (4),
    .CNT_W      (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .packet_in      (packet_in),
    .req_up_str     (req_up_str),
    .gnt_up_str     (gnt_up_str),
    .up_str_full    (up_str_full),
    .drain_en       (drain_en),
    .stats_clr      (stats_clr),
    .rx_valid       (rx_valid),
    .rx_src         (rx_src),
    .rx_pkt_id      (rx_pkt_id),
    .rx_latency     (rx_latency),
    .pkt_count      (pkt_count),
    .lat_sum        (lat_sum),
    .lat_max        (lat_max),
    .misroute_count (misroute_count),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  // Reference cycle counter: same reset and increment rule as the sink's.
  always @(posedge clk or negedge reset) begin
    if (!reset) tb_cyc <= '0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_pid_q.push_back(rx_pkt_id);
      $display("rx: src=%0d pkt_id=%0d latency=%0d", rx_src, rx_pkt_id, rx_latency);
    end
  end

  // Called at a negedge; returns at the negedge where the grant is seen.
  task automatic send_pkt(input logic [7:0] pid, input logic [5:0] src, input logic [5:0] dst,
                          input logic [11:0] inj, input string name);
    bit ok = 1'b0;
    packet_in  = {pid, src, dst, inj};
    req_up_str = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (gnt_up_str === 1'b1) ok = 1'b1;
    end
    req_up_str = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_grant: got no grant, required grant within 20 cycles", name);
    end else begin
      $display("tx %s: pkt_id=%0d src=%0d dst=%0d inj_ts=%0h granted", name, pid, src, dst, inj);
    end
  endtask

  task automatic clear_stats();
    @(negedge clk);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++;
    if (pkt_count !== 32'd0) begin
      errors++;
      $display("FAIL clear_pkt_count: got %0d required 0", pkt_count);
    end
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    drain_en   = 1'b1;
    req_up_str = 1'b1;
    packet_in  = {8'd1, 6'd4, 6'd9, 12'd0};
    repeat (3) @(negedge clk);
    checks++;
    if (gnt_up_str !== 1'b0) begin
      errors++; $display("FAIL reset_gnt: got %0b required 0", gnt_up_str);
    end
    checks++;
    if ({up_str_full, rx_valid, fifo_level} !== 5'd0) begin
      errors++; $display("FAIL reset_flags: got %0h required 0", {up_str_full, rx_valid, fifo_level});
    end
    checks++;
    if ({rx_src, rx_pkt_id, rx_latency, pkt_count, lat_sum, lat_max, misroute_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %0h required 0",
               {rx_src, rx_pkt_id, rx_latency, pkt_count, lat_sum, lat_max, misroute_count});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt_up_str !== 1'b1) begin
      errors++; $display("FAIL reset_first_gnt: got %0b required 1", gnt_up_str);
    end
    req_up_str = 1'b0;
    repeat (4) @(negedge clk);
    clear_stats();
  endtask

  task automatic test_single();
    send_pkt(8'd3, 6'd5, 6'd9, 12'(tb_cyc - 32'd20), "single");
    @(negedge clk);
    checks++;
    if (gnt_up_str !== 1'b0) begin
      errors++; $display("FAIL single_gnt_width: got %0b required 0", gnt_up_str);
    end
    checks++;
    if ({rx_valid, rx_src, rx_pkt_id, rx_latency} !== {1'b1, 6'd5, 8'd3, 12'd20}) begin
      errors++;
      $display("FAIL single_rx: got valid=%0b src=%0d pid=%0d lat=%0d required 1/5/3/20",
               rx_valid, rx_src, rx_pkt_id, rx_latency);
    end
    @(negedge clk);
    checks++;
    if ({pkt_count, lat_sum, lat_max, misroute_count} !== {32'd1, 32'd20, 12'd20, 32'd0}) begin
      errors++;
      $display("FAIL single_stats: got cnt=%0d sum=%0d max=%0d mis=%0d required 1/20/20/0",
               pkt_count, lat_sum, lat_max, misroute_count);
    end
  endtask

  task automatic test_backpressure();
    bit seen = 1'b0;
    drain_en = 1'b0;
    rx_pid_q.delete();
    for (int i = 0; i < 4; i++) send_pkt(8'(10 + i), 6'(i + 1), 6'd9, 12'd0, "bp");
    @(negedge clk);
    checks++;
    if ({up_str_full, fifo_level} !== {1'b1, 3'd4}) begin
      errors++; $display("FAIL bp_full: got full=%0b level=%0d required 1/4", up_str_full, fifo_level);
    end
    packet_in  = {8'd14, 6'd5, 6'd9, 12'd0};
    req_up_str = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (gnt_up_str === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL bp_hold: got grant while full, required none");
    end
    drain_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (gnt_up_str === 1'b1) seen = 1'b1;
    end
    req_up_str = 1'b0;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL bp_fifth_grant: got no grant, required grant after drain");
    end
    repeat (12) @(negedge clk);
    checks++;
    if (rx_pid_q.size() != 5) begin
      errors++; $display("FAIL bp_rx_count: got %0d required 5", rx_pid_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rx_pid_q[i] !== 8'(10 + i)) begin
        errors++; $display("FAIL bp_order[%0d]: got %0d required %0d", i, rx_pid_q[i], 10 + i);
      end
    end
    checks++;
    if ({up_str_full, fifo_level} !== 4'd0) begin
      errors++; $display("FAIL bp_drained: got full=%0b level=%0d required 0/0", up_str_full, fifo_level);
    end
  endtask

  task automatic test_ts_wrap();
    int n = 0;
    clear_stats();
    while (tb_cyc[11:0] != 12'h010 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tb_cyc[11:0] != 12'h010) begin
      errors++; $display("FAIL wrap_align: got cycle %0h required 010", tb_cyc[11:0]);
    end
    send_pkt(8'h21, 6'd7, 6'd9, 12'hFF0, "wrap");
    @(negedge clk);
    checks++;
    if ({rx_valid, rx_latency} !== {1'b1, 12'h020}) begin
      errors++; $display("FAIL wrap_latency: got valid=%0b lat=%0h required 1/020", rx_valid, rx_latency);
    end
    @(negedge clk);
    checks++;
    if ({lat_sum, lat_max} !== {32'h20, 12'h020}) begin
      errors++; $display("FAIL wrap_stats: got sum=%0h max=%0h required 20/020", lat_sum, lat_max);
    end
  endtask

  task automatic test_misroute();
    clear_stats();
    send_pkt(8'h40, 6'd1, 6'd2, 12'd0, "misroute");
    @(negedge clk);
    checks++;
    if ({rx_valid, rx_src, rx_pkt_id} !== {1'b1, 6'd1, 8'h40}) begin
      errors++;
      $display("FAIL misroute_rx: got valid=%0b src=%0d pid=%0h required 1/1/40", rx_valid, rx_src, rx_pkt_id);
    end
    @(negedge clk);
    checks++;
    if ({misroute_count, pkt_count} !== {32'd1, 32'd1}) begin
      errors++;
      $display("FAIL misroute_stats: got mis=%0d cnt=%0d required 1/1", misroute_count, pkt_count);
    end
  endtask

  task automatic test_clear_and_reset();
    int base;
    send_pkt(8'h50, 6'd3, 6'd9, 12'(tb_cyc - 32'd4), "clr");
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b1) begin
      errors++; $display("FAIL clr_rx_valid: got %0b required 1", rx_valid);
    end
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    checks++;
    if ({pkt_count, lat_sum, lat_max, misroute_count} !== '0) begin
      errors++;
      $display("FAIL clr_priority: got cnt=%0d sum=%0d max=%0d mis=%0d required 0/0/0/0",
               pkt_count, lat_sum, lat_max, misroute_count);
    end
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) send_pkt(8'(8'h60 + i), 6'd2, 6'd9, 12'd0, "queued");
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++; $display("FAIL queued_level: got %0d required 3", fifo_level);
    end
    base  = rx_cnt;
    reset = 1'b0;
    #1;
    checks++;
    if ({gnt_up_str, fifo_level} !== 4'd0) begin
      errors++; $display("FAIL midreset: got gnt=%0b level=%0d required 0/0", gnt_up_str, fifo_level);
    end
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    drain_en = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (rx_cnt != base) begin
      errors++; $display("FAIL midreset_no_rx: got %0d rx after reset required 0", rx_cnt - base);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_ts_wrap();
    test_misroute();
    test_clear_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
